// File: rtl/regs_wb.sv
// rtl/regs_wb.sv - integer register file (x0..x31) fed by write-back, with retirement tracking
// Optional feature macro REGS_BYPASS_EN: forward same-cycle write data to the read ports.
module regs_wb #(
  parameter int REG_NUM      = 32,
  parameter int RETIRE_CNT_W = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             inst_i,
  input  logic [31:0]             instaddr_i,
  input  logic                    regs_wen_i,
  input  logic [4:0]              rd_addr_i,
  input  logic [31:0]             rd_data_i,
  input  logic [4:0]              hold_en_i,
  input  logic [4:0]              rs1_addr_i,
  output logic [31:0]             rs1_data_o,
  input  logic [4:0]              rs2_addr_i,
  output logic [31:0]             rs2_data_o,
  output logic [RETIRE_CNT_W-1:0] retire_cnt_o,
  output logic [31:0]             last_pc_o
);

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  logic [31:0]             regs [REG_NUM];
  logic [RETIRE_CNT_W-1:0] retire_cnt_q;
  logic [31:0]             last_pc_q;
  logic                    wr_hit;
  logic                    retire;
  logic [3:0]              unused_hold;

  // Only the WB hold bit matters here; earlier stages' holds are irrelevant.
  assign unused_hold = hold_en_i[3:0];

  assign wr_hit = regs_wen_i && (rd_addr_i != 5'd0);
  assign retire = !hold_en_i[4] && (inst_i != INST_NOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      regs[rd_addr_i] <= rd_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_q <= '0;
      last_pc_q    <= '0;
    end else if (retire) begin
      retire_cnt_q <= retire_cnt_q + RETIRE_CNT_W'(1);
      last_pc_q    <= instaddr_i;
    end
  end

  // x0 is forced to zero last so forwarding can never leak onto it.
  always_comb begin
    rs1_data_o = regs[rs1_addr_i];
`ifdef REGS_BYPASS_EN
    if (wr_hit && (rs1_addr_i == rd_addr_i)) rs1_data_o = rd_data_i;
`endif
    if (rs1_addr_i == 5'd0) rs1_data_o = '0;
  end

  always_comb begin
    rs2_data_o = regs[rs2_addr_i];
`ifdef REGS_BYPASS_EN
    if (wr_hit && (rs2_addr_i == rd_addr_i)) rs2_data_o = rd_data_i;
`endif
    if (rs2_addr_i == 5'd0) rs2_data_o = '0;
  end

  assign retire_cnt_o = retire_cnt_q;
  assign last_pc_o    = last_pc_q;

endmodule
